register_token_parser: RTL

// Streaming assembler front-end parser for one register-operand token, fed one ASCII char per strobe.

---
 rtl/register_token_parser.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/register_token_parser.sv
// Streaming parser for one assembler register operand (r/x + decimal digits or RISC-V ABI name),
// one ASCII character per strobe; reports the index on a terminating delimiter.
module register_token_parser #(
   parameter int NUM_REGS = 32,
   parameter bit ABI_EN   = 1'b1,
   parameter bit X_PREFIX = 1'b1
) (
   input  logic                        clk_in,
   input  logic                        rst_n_in,
   input  logic                        valid_data,
   input  logic                        new_character,
   input  logic [7:0]                  incoming_ascii,
   output logic [$clog2(NUM_REGS)-1:0] register,
   output logic                        done_flag,
   output logic                        error_flag
);

   localparam int REG_W = $clog2(NUM_REGS);

   localparam logic [7:0] CH_SP = 8'h20;
   localparam logic [7:0] CH_A  = 8'h61;
   localparam logic [7:0] CH_E  = 8'h65;
   localparam logic [7:0] CH_F  = 8'h66;
   localparam logic [7:0] CH_G  = 8'h67;
   localparam logic [7:0] CH_O  = 8'h6F;
   localparam logic [7:0] CH_P  = 8'h70;
   localparam logic [7:0] CH_R  = 8'h72;
   localparam logic [7:0] CH_S  = 8'h73;
   localparam logic [7:0] CH_T  = 8'h74;
   localparam logic [7:0] CH_X  = 8'h78;
   localparam logic [7:0] CH_Z  = 8'h7A;

   typedef enum logic [3:0] {
      S_IDLE, S_NUM1, S_NUM2, S_ABI_L, S_ABI_D1, S_ABI_D2,
      S_Z_E, S_Z_R, S_Z_O, S_END, S_ERROR
   } state_t;

   state_t           state_q, state_d;
   logic [6:0]       acc_q, acc_d;
   logic [7:0]       letter_q, letter_d;
   logic [REG_W-1:0] register_q, register_d;
   logic             done_q, done_d;
   logic             error_q, error_d;

   logic [7:0]       ch_s;
   logic [3:0]       dig_s;
   logic             is_dig_s;
   logic             is_delim_s;
   logic             resolve_s;
   logic [6:0]       acc_x10_s;

   function automatic logic [7:0] to_lower(input logic [7:0] c);
      if (c >= 8'h41 && c <= 8'h5A) begin
         return c + 8'h20;
      end else begin
         return c;
      end
   endfunction

   function automatic logic is_delim(input logic [7:0] c);
      return (c == 8'h20) || (c == 8'h2C) || (c == 8'h29) || (c == 8'h0A) || (c == 8'h0D);
   endfunction

   // Character classification shared by every state.
   always_comb begin
      ch_s       = to_lower(incoming_ascii);
      dig_s      = ch_s[3:0];
      is_dig_s   = (ch_s >= 8'h30) && (ch_s <= 8'h39);
      is_delim_s = is_delim(ch_s);
      acc_x10_s  = (acc_q << 3) + (acc_q << 1) + {3'd0, dig_s};
   end

   // Next-state, accumulator and output computation.
   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      letter_d   = letter_q;
      register_d = register_q;
      done_d     = 1'b0;
      resolve_s  = 1'b0;
      if (!valid_data) begin
         state_d  = S_IDLE;
         acc_d    = 7'd0;
         letter_d = 8'h00;
      end else if (new_character) begin
         case (state_q)
            S_IDLE: begin
               if (ch_s == CH_SP) begin
                  state_d = S_IDLE;
               end else if (ch_s == CH_R || (X_PREFIX && ch_s == CH_X)) begin
                  state_d  = S_NUM1;
                  letter_d = ch_s;
               end else if (ABI_EN && (ch_s == CH_T || ch_s == CH_S || ch_s == CH_A ||
                                       ch_s == CH_G || ch_s == CH_F)) begin
                  state_d  = S_ABI_L;
                  letter_d = ch_s;
               end else if (ABI_EN && ch_s == CH_Z) begin
                  state_d = S_Z_E;
               end else begin
                  state_d = S_ERROR;
               end
            end
            // "r" followed by "a" is the ABI name ra, not a numeric register.
            S_NUM1: begin
               if (is_dig_s) begin
                  acc_d   = {3'd0, dig_s};
                  state_d = S_NUM2;
               end else if (ABI_EN && letter_q == CH_R && ch_s == CH_A) begin
                  acc_d   = 7'd1;
                  state_d = S_END;
               end else begin
                  state_d = S_ERROR;
               end
            end
            S_NUM2: begin
               if (is_dig_s) begin
                  if (acc_q == 7'd0) begin
                     state_d = S_ERROR;
                  end else begin
                     acc_d   = acc_x10_s;
                     state_d = S_END;
                  end
               end else if (is_delim_s) begin
                  resolve_s = 1'b1;
               end else begin
                  state_d = S_ERROR;
               end
            end
            S_ABI_L: begin
               if (ch_s == CH_P && (letter_q == CH_S || letter_q == CH_G ||
                                    letter_q == CH_T || letter_q == CH_F)) begin
                  case (letter_q)
                     CH_S:    acc_d = 7'd2;
                     CH_G:    acc_d = 7'd3;
                     CH_T:    acc_d = 7'd4;
                     default: acc_d = 7'd8;
                  endcase
                  state_d = S_END;
               end else if (is_dig_s) begin
                  case (letter_q)
                     CH_T: begin
                        if (dig_s <= 4'd2) begin
                           acc_d   = {3'd0, dig_s} + 7'd5;
                           state_d = S_ABI_D1;
                        end else if (dig_s <= 4'd6) begin
                           acc_d   = {3'd0, dig_s} + 7'd25;
                           state_d = S_ABI_D1;
                        end else begin
                           state_d = S_ERROR;
                        end
                     end
                     CH_S: begin
                        if (dig_s <= 4'd1) begin
                           acc_d = {3'd0, dig_s} + 7'd8;
                        end else begin
                           acc_d = {3'd0, dig_s} + 7'd16;
                        end
                        state_d = S_ABI_D1;
                     end
                     CH_A: begin
                        if (dig_s <= 4'd7) begin
                           acc_d   = {3'd0, dig_s} + 7'd10;
                           state_d = S_ABI_D1;
                        end else begin
                           state_d = S_ERROR;
                        end
                     end
                     default: state_d = S_ERROR;
                  endcase
               end else begin
                  state_d = S_ERROR;
               end
            end
            // Only s1 may grow a second digit (s10, s11).
            S_ABI_D1: begin
               if (is_delim_s) begin
                  resolve_s = 1'b1;
               end else if (is_dig_s && letter_q == CH_S && acc_q == 7'd9 && dig_s <= 4'd1) begin
                  acc_d   = {3'd0, dig_s} + 7'd26;
                  state_d = S_ABI_D2;
               end else begin
                  state_d = S_ERROR;
               end
            end
            S_Z_E:   state_d = (ch_s == CH_E) ? S_Z_R : S_ERROR;
            S_Z_R:   state_d = (ch_s == CH_R) ? S_Z_O : S_ERROR;
            S_Z_O: begin
               if (ch_s == CH_O) begin
                  acc_d   = 7'd0;
                  state_d = S_END;
               end else begin
                  state_d = S_ERROR;
               end
            end
            S_ABI_D2, S_END: begin
               if (is_delim_s) begin
                  resolve_s = 1'b1;
               end else begin
                  state_d = S_ERROR;
               end
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_ERROR;
         endcase
      end else begin
         state_d = state_q;
      end

      if (resolve_s) begin
         if ({25'd0, acc_q} >= NUM_REGS) begin
            state_d = S_ERROR;
         end else begin
            register_d = acc_q[REG_W-1:0];
            done_d     = 1'b1;
            acc_d      = 7'd0;
            state_d    = S_IDLE;
         end
      end else begin
         done_d = 1'b0;
      end
      error_d = (state_d == S_ERROR);
   end

   // State and output registers.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q    <= S_IDLE;
         acc_q      <= 7'd0;
         letter_q   <= 8'h00;
         register_q <= '0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         letter_q   <= letter_d;
         register_q <= register_d;
         done_q     <= done_d;
         error_q    <= error_d;
      end
   end

   assign register   = register_q;
   assign done_flag  = done_q;
   assign error_flag = error_q;

endmodule
